// File: rtl/key_sched_ctrl.sv
// Key-schedule sequencer: drives an external single-round key transform NR times and keeps an 11-entry key store.
// Optional build macro KSC_KEY_CACHE_EN skips expansion when the previously expanded key is requested again.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i; key store readable
// LAUNCH | tf_start_o pulse for the current round; may capture same cycle
// WAIT   | waiting for tf_done_i of the current round
// DONE   | done_o pulse, back to IDLE
module key_sched_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [127:0] key_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         tf_start_o,
   output logic [127:0] tf_key_o,
   output logic [3:0]   tf_round_o,
   input  logic [127:0] tf_key_i,
   input  logic         tf_done_i,
   input  logic [3:0]   rk_addr_i,
   output logic [127:0] rk_data_o,
   output logic         rk_ok_o,
   output logic [10:0]  rk_valid_o,
   output logic         cache_hit_o
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] NR_L = 4'(NR);

   state_t        state, state_nx;
   logic [3:0]    round;
   logic [127:0]  rk [0:10];
   logic [10:0]   rk_valid;
   logic [15:0]   valid_ext;
   logic          load, capture, last, hit_cond;

   assign last       = (round == NR_L);
   assign rk_valid_o = rk_valid;
   assign valid_ext  = {5'b0, rk_valid};

`ifdef KSC_KEY_CACHE_EN
   logic hit_q;

   assign hit_cond    = (key_i == rk[0]) && (&rk_valid[NR:0]);
   assign cache_hit_o = hit_q;

   always_ff @(posedge clk) begin
      if (rst) hit_q <= 1'b0;
      else     hit_q <= (state == S_IDLE) && start_i && hit_cond;
   end
`else
   assign hit_cond    = 1'b0;
   assign cache_hit_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      tf_start_o = 1'b0;
      load       = 1'b0;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               if (hit_cond) begin
                  state_nx = S_DONE;
               end else begin
                  load     = 1'b1;
                  state_nx = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            tf_start_o = 1'b1;
            busy_o     = 1'b1;
            // zero-latency transform: capture in the launch cycle itself
            if (tf_done_i) begin
               capture  = 1'b1;
               state_nx = last ? S_DONE : S_LAUNCH;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            busy_o = 1'b1;
            if (tf_done_i) begin
               capture  = 1'b1;
               state_nx = last ? S_DONE : S_LAUNCH;
            end
         end
         S_DONE: begin
            done_o   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         round    <= 4'd0;
         rk_valid <= 11'b0;
         for (int i = 0; i < 11; i++) rk[i] <= '0;
      end else begin
         if (load) begin
            rk[0]    <= key_i;
            rk_valid <= 11'b1;
            round    <= 4'd1;
         end
         if (capture) begin
            for (int i = 1; i <= NR; i++) begin
               if (round == 4'(i)) begin
                  rk[i]       <= tf_key_i;
                  rk_valid[i] <= 1'b1;
               end
            end
            if (!last) round <= round + 4'd1;
         end
         if (state == S_DONE) round <= 4'd0;
      end
   end

   always_comb begin
      tf_key_o   = '0;
      tf_round_o = 4'd0;
      if (state == S_LAUNCH || state == S_WAIT) begin
         tf_round_o = round;
         for (int i = 1; i <= 10; i++) begin
            if (round == 4'(i)) tf_key_o = rk[i-1];
         end
      end
   end

   // read port sees the registered store, so a same-cycle capture shows old data
   always_comb begin
      rk_data_o = '0;
      for (int i = 0; i <= 10; i++) begin
         if (rk_addr_i == 4'(i)) rk_data_o = rk[i];
      end
      rk_ok_o = (rk_addr_i <= NR_L) && valid_ext[rk_addr_i];
   end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: the bench plays the AES round-key transform and checks the
// sequencer against an FIPS-197 key expansion model and a model of the key store.
module tb_key_sched_ctrl;

   localparam int NR = 10;
`ifdef KSC_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         start_i;
   logic [127:0] key_i;
   logic         busy_o;
   logic         done_o;
   logic         tf_start_o;
   logic [127:0] tf_key_o;
   logic [3:0]   tf_round_o;
   logic [127:0] tf_key_i;
   logic         tf_done_i;
   logic [3:0]   rk_addr_i;
   logic [127:0] rk_data_o;
   logic         rk_ok_o;
   logic [10:0]  rk_valid_o;
   logic         cache_hit_o;

   key_sched_ctrl #(.NR(NR)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i),
      .busy_o(busy_o), .done_o(done_o), .tf_start_o(tf_start_o),
      .tf_key_o(tf_key_o), .tf_round_o(tf_round_o), .tf_key_i(tf_key_i),
      .tf_done_i(tf_done_i), .rk_addr_i(rk_addr_i), .rk_data_o(rk_data_o),
      .rk_ok_o(rk_ok_o), .rk_valid_o(rk_valid_o), .cache_hit_o(cache_hit_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   logic [7:0]   sbox [256];
   logic [127:0] mrk [0:10];
   logic [10:0]  mvalid;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // AES-128 next round key from the previous one and the round number
   function automatic logic [127:0] aes_next(input logic [127:0] prev, input logic [3:0] r);
      logic [7:0]  rc;
      logic [31:0] w0, w1, w2, w3, rot, tmp, n0, n1, n2, n3;
      rc = 8'h01;
      for (int k = 1; k < int'(r); k++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      {w0, w1, w2, w3} = prev;
      rot = {w3[23:0], w3[31:24]};
      tmp = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]} ^ {rc, 24'h0};
      n0 = w0 ^ tmp; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_read();
      int  a;
      logic exp_ok;
      a = int'(rk_addr_i);
      exp_ok = (a <= NR) ? mvalid[a] : 1'b0;
      chk("rk_ok", 128'(rk_ok_o), 128'(exp_ok));
      if (a > 10) chk("rk_data_hi", rk_data_o, 128'h0);
      else        chk("rk_data", rk_data_o, mrk[a]);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_busy"},     128'(busy_o),      128'(0));
      chk({tag, "_done"},     128'(done_o),      128'(0));
      chk({tag, "_tf_start"}, 128'(tf_start_o),  128'(0));
      chk({tag, "_hit"},      128'(cache_hit_o), 128'(0));
      chk({tag, "_tf_round"}, 128'(tf_round_o),  128'(0));
      chk({tag, "_tf_key"},   tf_key_o,          128'h0);
      chk({tag, "_valid"},    128'(rk_valid_o),  128'(0));
      check_read();
   endtask

   task automatic model_clear();
      for (int i = 0; i <= 10; i++) mrk[i] = '0;
      mvalid = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start_i = 1'b0; tf_done_i = 1'b0; rk_addr_i = 4'd0;
      repeat (2) @(posedge clk);
      model_clear();
      @(negedge clk);
      check_reset_outs("reset");
      rst = 1'b0;
   endtask

   task automatic readout();
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         rk_addr_i = 4'(a);
         #1;
         check_read();
      end
   endtask

   task automatic run_exp(input logic [127:0] key, input int lat, input bit noise,
                          input int abort_r, input bit fix5);
      logic [127:0] ref_rk [0:10];
      logic [127:0] lk, pend_v;
      logic [3:0]   lr;
      bit           hit, active, done_seen, aborted;
      int           launches, cnt, c, exp_lat, pend_r;
      ref_rk[0] = key;
      for (int r = 1; r <= NR; r++) ref_rk[r] = aes_next(ref_rk[r-1], 4'(r));
      hit = CACHE_EN && (key == mrk[0]) && (&mvalid[NR:0]);
      exp_lat = hit ? 1 : 1 + NR * (lat + 1);
      launches = 0; active = 0; done_seen = 0; aborted = 0; pend_r = -1;
      cnt = 0; lr = 4'd0; lk = '0; pend_v = '0;
      @(negedge clk);
      if (noise) begin
         tf_done_i = 1'b1; tf_key_i = rand128();
         @(negedge clk);
         tf_done_i = 1'b0;
      end
      start_i = 1'b1; key_i = key;
      rk_addr_i = fix5 ? 4'd5 : 4'($urandom_range(0, 15));
      @(posedge clk);
      if (!hit) begin
         mrk[0] = key; mvalid = 11'b1;
      end
      @(negedge clk);
      start_i = 1'b0;
      c = 1;
      while (!done_seen && !aborted && c <= 400) begin
         if (pend_r >= 0) begin
            mrk[pend_r] = pend_v; mvalid[pend_r] = 1'b1; pend_r = -1;
         end
         check_read();
         if (done_o) begin
            done_seen = 1;
            chk("done_latency", 128'(c), 128'(exp_lat));
            chk("cache_hit", 128'(cache_hit_o), 128'(hit));
            chk("launches", 128'(launches), 128'(hit ? 0 : NR));
            chk("busy_in_done", 128'(busy_o), 128'(0));
         end else begin
            chk("busy", 128'(busy_o), 128'(1));
         end
         if (tf_start_o) begin
            launches++;
            chk("tf_round", 128'(tf_round_o), 128'(launches));
            chk("tf_key", tf_key_o, (launches <= NR) ? ref_rk[launches-1] : 128'h0);
            active = 1; cnt = lat; lr = tf_round_o; lk = tf_key_o;
         end else if (active) begin
            chk("tf_round_hold", 128'(tf_round_o), 128'(lr));
            chk("tf_key_hold", tf_key_o, lk);
         end
         tf_done_i = 1'b0;
         if (active) begin
            if (cnt == 0) begin
               tf_done_i = 1'b1;
               tf_key_i  = aes_next(lk, lr);
               pend_r = int'(lr); pend_v = tf_key_i; active = 0;
            end else begin
               cnt--;
            end
         end
         if (abort_r > 0 && active && !tf_start_o && !tf_done_i && int'(lr) == abort_r) begin
            rst = 1'b1; rk_addr_i = 4'd0;
            @(posedge clk);
            model_clear();
            @(negedge clk);
            check_reset_outs("abort");
            rst = 1'b0;
            tf_done_i = 1'b1; tf_key_i = rand128();
            @(posedge clk);
            @(negedge clk);
            tf_done_i = 1'b0;
            chk("late_done_valid", 128'(rk_valid_o), 128'(0));
            chk("late_done_busy", 128'(busy_o), 128'(0));
            chk("late_done_start", 128'(tf_start_o), 128'(0));
            aborted = 1;
         end else begin
            if (noise && !done_seen) begin
               start_i = 1'($urandom_range(0, 1)); key_i = rand128();
            end else begin
               start_i = 1'b0;
            end
            rk_addr_i = fix5 ? 4'd5 : 4'($urandom_range(0, 15));
            @(posedge clk);
            @(negedge clk);
            c++;
         end
      end
      start_i = 1'b0; tf_done_i = 1'b0;
      if (done_seen) begin
         chk("done_pulse_width", 128'(done_o), 128'(0));
         chk("idle_busy", 128'(busy_o), 128'(0));
         chk("idle_hit", 128'(cache_hit_o), 128'(0));
         chk("idle_tf_start", 128'(tf_start_o), 128'(0));
      end else if (!aborted) begin
         chk("done_timeout", 128'(0), 128'(1));
      end
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

   initial begin
      logic [127:0] k;
      rst = 1'b1; start_i = 1'b0; key_i = '0; tf_key_i = '0; tf_done_i = 1'b0; rk_addr_i = 4'd0;
      model_clear();
      build_sbox();

      do_reset();
      run_exp(FIPS_KEY, 1, 0, 0, 0);
      readout();
      @(negedge clk); rk_addr_i = 4'd1; #1;
      chk("fips_rk1", rk_data_o, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      @(negedge clk); rk_addr_i = 4'd10; #1;
      chk("fips_rk10", rk_data_o, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

      do_reset();
      run_exp(FIPS_KEY, 0, 0, 0, 0);
      readout();
      do_reset();
      run_exp(FIPS_KEY, 3, 0, 0, 0);
      readout();

      do_reset();
      run_exp(FIPS_KEY, 1, 1, 0, 1);
      readout();

      do_reset();
      run_exp(FIPS_KEY, 2, 0, 4, 0);
      k = rand128();
      run_exp(k, 1, 0, 0, 0);
      readout();

      run_exp(k, 1, 0, 0, 0);
      readout();
      run_exp(rand128(), 2, 0, 0, 0);
      readout();

      for (int it = 0; it < 6; it++) begin
         run_exp(rand128(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0);
         readout();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
